// File: rtl/can_dma_pkg.sv
// Shared constants and types for the CAN DMA blocks: memory map, FSM encoding,
// word order within a received frame.
package can_dma_pkg;

  localparam logic [19:0] RX_ADDR_SETTING = 20'hB0001;
  localparam logic [19:0] RX_ADDR_DATA_1  = 20'hB0002;
  localparam logic [19:0] RX_ADDR_DATA_2  = 20'hB0003;

  localparam int FRAME_VALID_BIT = 31;

  localparam logic [1:0] IDX_DATA_HI = 2'd0;
  localparam logic [1:0] IDX_DATA_LO = 2'd1;
  localparam logic [1:0] IDX_SETTING = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } rx_dma_state_e;

endpackage

// File: rtl/can_rx_frame_fifo.sv
// Frame FIFO: show-ahead read, extra-bit occupancy counter, no overflow guard
// (the parent decides whether a push is allowed).
module can_rx_frame_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_o  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   level_o <= level_o + LVL_W'(1);
        2'b01:   level_o <= level_o - LVL_W'(1);
        default: ;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_o == LVL_W'(DEPTH));
  assign empty_o = (level_o == '0);

endmodule

// File: rtl/can_rx_dma_writer.sv
// Buffers received CAN frames and writes each one to memory as three DMA words,
// setting word last with its valid flag forced high.
//
//   state | meaning
//   IDLE  | waiting for a buffered frame and enable_i
//   LOAD  | present address/data of word idx
//   REQ   | issue wr_en once memory is not busy
//   WAIT  | wait for wr_done or write timeout
//   DONE  | pulse frame_stored_o
module can_rx_dma_writer
  import can_dma_pkg::*;
#(
  parameter int                    DATA_WIDTH            = 32,
  parameter int                    ADDR_WIDTH            = 20,
  parameter int                    FIFO_DEPTH            = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SETTING_RECEIVED = RX_ADDR_SETTING,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_RECEIVED_1  = RX_ADDR_DATA_1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_DATA_RECEIVED_2  = RX_ADDR_DATA_2,
  parameter int                    WR_TIMEOUT_CYC        = 1024,
  localparam int                   LVL_W                 = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  rx_frame_ready_i,
  input  logic [63:0]           rx_data_i,
  input  logic [31:0]           rx_setting_i,
  output logic [DATA_WIDTH-1:0] data_wr,
  output logic [ADDR_WIDTH-1:0] addr_wr,
  output logic                  wr_en,
  input  logic                  wr_done,
  input  logic                  wr_busy,
  output logic                  frame_stored_o,
  output logic                  overflow_o,
  output logic [7:0]            drop_count_o,
  output logic                  err_timeout_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic                  busy_o
);

  localparam int                TMR_W    = $clog2(WR_TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(WR_TIMEOUT_CYC - 1);

  rx_dma_state_e    state_q, state_d;
  logic [95:0]      frame_q, fifo_rdata;
  logic [31:0]      setting_word;
  logic [1:0]       idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic             fifo_full, fifo_empty;
  logic             push, pop, drop, tmr_expired;

  // A full FIFO still accepts a frame when the FSM frees a slot in the same cycle.
  assign push        = rx_frame_ready_i & (~fifo_full | pop);
  assign drop        = rx_frame_ready_i & ~push;
  assign tmr_expired = (tmr_q == '0);

  can_rx_frame_fifo #(
    .WIDTH (96),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({rx_setting_i, rx_data_i}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty && enable_i) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_REQ;
      ST_REQ:  if (!wr_busy) state_d = ST_WAIT;
      ST_WAIT: begin
        if (wr_done)          state_d = (idx_q == IDX_SETTING) ? ST_DONE : ST_LOAD;
        else if (tmr_expired) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop            = 1'b0;
    wr_en          = 1'b0;
    frame_stored_o = 1'b0;
    busy_o         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        pop    = !fifo_empty && enable_i;
      end
      ST_REQ:  wr_en = !wr_busy;
      ST_DONE: frame_stored_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    setting_word                  = frame_q[95:64];
    setting_word[FRAME_VALID_BIT] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q       <= '0;
      idx_q         <= IDX_DATA_HI;
      tmr_q         <= '0;
      addr_wr       <= '0;
      data_wr       <= '0;
      overflow_o    <= 1'b0;
      drop_count_o  <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      if (pop) begin
        frame_q <= fifo_rdata;
        idx_q   <= IDX_DATA_HI;
      end
      if (state_q == ST_LOAD) begin
        case (idx_q)
          IDX_DATA_HI: begin
            addr_wr <= ADDR_DATA_RECEIVED_1;
            data_wr <= frame_q[63:32];
          end
          IDX_DATA_LO: begin
            addr_wr <= ADDR_DATA_RECEIVED_2;
            data_wr <= frame_q[31:0];
          end
          default: begin
            addr_wr <= ADDR_SETTING_RECEIVED;
            data_wr <= setting_word;
          end
        endcase
      end
      if (wr_en)                                     tmr_q <= TMR_LOAD;
      else if (state_q == ST_WAIT && !tmr_expired)   tmr_q <= tmr_q - TMR_W'(1);
      if (state_q == ST_WAIT && wr_done && idx_q != IDX_SETTING)
        idx_q <= idx_q + 2'd1;
      if (state_q == ST_WAIT && !wr_done && tmr_expired)
        err_timeout_o <= 1'b1;
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_count_o != 8'hFF) drop_count_o <= drop_count_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_can_rx_dma_writer.sv
// Self-checking bench for can_rx_dma_writer: random frames against a queue model
// of the expected DMA word stream, plus directed corner scenarios.
module tb_can_rx_dma_writer;

  localparam int WR_TIMEOUT_CYC = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        rx_frame_ready_i = 1'b0;
  logic [63:0] rx_data_i = '0;
  logic [31:0] rx_setting_i = '0;
  logic [31:0] data_wr;
  logic [19:0] addr_wr;
  logic        wr_en;
  logic        wr_done = 1'b0;
  logic        wr_busy = 1'b0;
  logic        frame_stored_o, overflow_o, err_timeout_o, busy_o;
  logic [7:0]  drop_count_o;
  logic [2:0]  fifo_level_o;

  int checks = 0;
  int errors = 0;

  logic [51:0] wr_log[$];
  logic [51:0] exp_q[$];
  int          stored_cnt = 0;
  int          proto_viol = 0;
  logic        prev_wr_en = 1'b0;

  bit          resp_on = 1'b1;
  int          done_delay = 2;
  logic [19:0] skip_addr = '0;
  int          manual_req = 0;
  int          manual_ack = 0;

  always #5 clk_i = ~clk_i;

  can_rx_dma_writer dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .rx_frame_ready_i (rx_frame_ready_i),
    .rx_data_i        (rx_data_i),
    .rx_setting_i     (rx_setting_i),
    .data_wr          (data_wr),
    .addr_wr          (addr_wr),
    .wr_en            (wr_en),
    .wr_done          (wr_done),
    .wr_busy          (wr_busy),
    .frame_stored_o   (frame_stored_o),
    .overflow_o       (overflow_o),
    .drop_count_o     (drop_count_o),
    .err_timeout_o    (err_timeout_o),
    .fifo_level_o     (fifo_level_o),
    .busy_o           (busy_o)
  );

  // Bus monitor: logs every write and flags requests issued while busy or held >1 cycle.
  always @(negedge clk_i) begin
    if (wr_en === 1'b1) begin
      wr_log.push_back({addr_wr, data_wr});
      if (wr_busy !== 1'b0 || prev_wr_en === 1'b1) proto_viol++;
    end
    if (frame_stored_o === 1'b1) stored_cnt++;
    prev_wr_en = wr_en;
  end

  // Memory responder.
  initial forever begin
    @(negedge clk_i);
    if (manual_req != manual_ack) begin
      manual_ack = manual_req;
      wr_done = 1'b1;
      @(posedge clk_i); #1 wr_done = 1'b0;
    end else if (wr_en === 1'b1 && resp_on && addr_wr !== skip_addr) begin
      repeat (done_delay) @(posedge clk_i);
      #1 wr_done = 1'b1;
      @(posedge clk_i); #1 wr_done = 1'b0;
    end
  end

  // Reference: a frame becomes data high, data low, then the setting word with bit 31 set.
  function automatic void model_frame(input logic [95:0] f, input int nwords);
    logic [31:0] setting;
    setting = f[95:64];
    setting[31] = 1'b1;
    if (nwords > 0) exp_q.push_back({20'hB0002, f[63:32]});
    if (nwords > 1) exp_q.push_back({20'hB0003, f[31:0]});
    if (nwords > 2) exp_q.push_back({20'hB0001, setting});
  endfunction

  function automatic logic [95:0] rand_frame();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic send_frame(input logic [95:0] f);
    rx_setting_i     = f[95:64];
    rx_data_i        = f[63:0];
    rx_frame_ready_i = 1'b1;
    cycle();
    rx_frame_ready_i = 1'b0;
  endtask

  task automatic wait_stored(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget; i++) begin
      if (stored_cnt >= target) break;
      cycle();
    end
    ok = (stored_cnt >= target);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if ({data_wr, addr_wr, wr_en, frame_stored_o, overflow_o, drop_count_o,
         err_timeout_o, fifo_level_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h addr=%h en=%b st=%b ovf=%b drop=%0d to=%b lvl=%0d busy=%b required all 0",
               data_wr, addr_wr, wr_en, frame_stored_o, overflow_o, drop_count_o, err_timeout_o, fifo_level_o, busy_o);
    end
    cycle();
  endtask

  task automatic test_single_frame();
    int base, s0, lat;
    bit ok;
    logic [95:0] f;
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete();
    enable_i = 1'b1; done_delay = 2;
    f = {32'h0000_1234, 64'h0123_4567_89AB_CDEF};
    model_frame(f, 3);
    send_frame(f);
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (wr_en === 1'b1) begin lat = i; break; end
    end
    cycle();
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d edges after push required 2", lat);
    end
    wait_stored(s0 + 1, 200, ok);
    repeat (5) cycle();
    checks++;
    if (stored_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_stored_pulses: got %0d required 1", stored_cnt - s0);
    end
    checks++;
    if (wr_log.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL single_write_count: got %0d required %0d", wr_log.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL single_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int base, s0;
    bit ok, seen;
    logic [19:0] held_addr;
    logic [31:0] held_data;
    logic [95:0] f;
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete();
    f = rand_frame();
    model_frame(f, 3);
    wr_busy = 1'b1;
    send_frame(f);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (wr_en !== 1'b0) seen = 1'b1;
    end
    cycle();
    checks++;
    if (seen || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got wr_en_seen=%b busy_o=%b required 0/1", seen, busy_o);
    end
    held_addr = addr_wr; held_data = data_wr;
    wr_busy = 1'b0;
    @(negedge clk_i);
    checks++;
    if (wr_en !== 1'b1 || addr_wr !== held_addr || data_wr !== held_data || {addr_wr, data_wr} !== exp_q[0]) begin
      errors++;
      $display("FAIL bp_release: got en=%b %h_%h required en=1 %h", wr_en, addr_wr, data_wr, exp_q[0]);
    end
    cycle();
    wait_stored(s0 + 1, 200, ok);
    repeat (3) cycle();
    checks++;
    if (!ok || wr_log.size() - base != 3) begin
      errors++;
      $display("FAIL bp_complete: got stored=%b writes=%0d required 1/3", ok, wr_log.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base, s0, total, n;
    bit ok;
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete(); total = 0;
    for (int r = 0; r < 4; r++) begin
      done_delay = $urandom_range(1, 4);
      n = $urandom_range(2, 4);
      for (int k = 0; k < n; k++) begin
        logic [95:0] f;
        f = rand_frame();
        model_frame(f, 3);
        send_frame(f);
        repeat ($urandom_range(0, 2)) cycle();
      end
      total += n;
      wait_stored(s0 + total, 800, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_round%0d_stored: got %0d required %0d", r, stored_cnt - s0, total);
      end
    end
    repeat (5) cycle();
    checks++;
    if (wr_log.size() - base != exp_q.size() || drop_count_o !== 8'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_summary: got writes=%0d drop=%0d ovf=%b required %0d/0/0",
               wr_log.size() - base, drop_count_o, overflow_o, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
    done_delay = 2;
  endtask

  task automatic test_overflow();
    int base, s0;
    bit ok;
    logic [95:0] fs[6];
    do_reset();
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete();
    enable_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      fs[k] = rand_frame();
      send_frame(fs[k]);
    end
    @(negedge clk_i);
    checks++;
    if (fifo_level_o !== 3'd4 || drop_count_o !== 8'd2 || overflow_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_state: got lvl=%0d drop=%0d ovf=%b busy=%b required 4/2/1/0",
               fifo_level_o, drop_count_o, overflow_o, busy_o);
    end
    cycle();
    for (int k = 0; k < 4; k++) model_frame(fs[k], 3);
    enable_i = 1'b1;
    wait_stored(s0 + 4, 400, ok);
    repeat (8) cycle();
    checks++;
    if (stored_cnt - s0 != 4 || fifo_level_o !== 3'd0 || wr_log.size() - base != 12) begin
      errors++;
      $display("FAIL ovf_drain: got stored=%0d lvl=%0d writes=%0d required 4/0/12",
               stored_cnt - s0, fifo_level_o, wr_log.size() - base);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL ovf_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    int base, s0;
    bit ok;
    logic [95:0] f;
    do_reset();
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete();
    enable_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      f = rand_frame();
      model_frame(f, 3);
      send_frame(f);
    end
    f = rand_frame();
    model_frame(f, 3);
    enable_i = 1'b1;
    send_frame(f);
    @(negedge clk_i);
    checks++;
    if (fifo_level_o !== 3'd4 || drop_count_o !== 8'd0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_state: got lvl=%0d drop=%0d ovf=%b required 4/0/0",
               fifo_level_o, drop_count_o, overflow_o);
    end
    cycle();
    wait_stored(s0 + 5, 500, ok);
    repeat (5) cycle();
    checks++;
    if (!ok || wr_log.size() - base != 15) begin
      errors++;
      $display("FAIL fullpop_drain: got stored=%0d writes=%0d required 5/15", stored_cnt - s0, wr_log.size() - base);
    end else begin
      for (int i = 0; i < 15; i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fullpop_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int base, s0, n;
    bit ok;
    logic [95:0] fa, fb;
    do_reset();
    base = wr_log.size(); s0 = stored_cnt; exp_q.delete();
    enable_i = 1'b1; done_delay = 2; skip_addr = 20'hB0003;
    fa = rand_frame();
    model_frame(fa, 2);
    send_frame(fa);
    for (int i = 0; i < 50; i++) begin
      if (wr_log.size() >= base + 2) break;
      cycle();
    end
    n = 0;
    while (err_timeout_o !== 1'b1 && n < WR_TIMEOUT_CYC + 50) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (n < WR_TIMEOUT_CYC || n > WR_TIMEOUT_CYC + 2 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got %0d cycles busy=%b required %0d..%0d busy=0",
               n, busy_o, WR_TIMEOUT_CYC, WR_TIMEOUT_CYC + 2);
    end
    cycle();
    skip_addr = '0;
    fb = rand_frame();
    model_frame(fb, 3);
    send_frame(fb);
    wait_stored(s0 + 1, 200, ok);
    repeat (5) cycle();
    checks++;
    if (!ok || err_timeout_o !== 1'b1 || stored_cnt - s0 != 1 || wr_log.size() - base != 5) begin
      errors++;
      $display("FAIL timeout_next: got stored=%0d err=%b writes=%0d required 1/1/5",
               stored_cnt - s0, err_timeout_o, wr_log.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_log[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL timeout_write%0d: got %h required %h", i, wr_log[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int base, s0;
    bit bad;
    base = wr_log.size(); s0 = stored_cnt;
    resp_on = 1'b0; enable_i = 1'b1;
    send_frame(rand_frame());
    for (int i = 0; i < 50; i++) begin
      if (wr_log.size() >= base + 1) break;
      cycle();
    end
    cycle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({data_wr, addr_wr, wr_en, frame_stored_o, overflow_o, drop_count_o,
         err_timeout_o, fifo_level_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL midwait_reset: got data=%h addr=%h en=%b to=%b lvl=%0d busy=%b required all 0",
               data_wr, addr_wr, wr_en, err_timeout_o, fifo_level_o, busy_o);
    end
    manual_req++;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0 || wr_en !== 1'b0 || frame_stored_o !== 1'b0 || fifo_level_o !== 3'd0) bad = 1'b1;
    end
    checks++;
    if (bad || wr_log.size() - base != 1 || stored_cnt != s0) begin
      errors++;
      $display("FAIL midwait_late_done: got activity=%b writes=%0d stored=%0d required 0/1/0",
               bad, wr_log.size() - base, stored_cnt - s0);
    end
    cycle();
    resp_on = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_timeout();
    test_reset_mid_wait();
    checks++;
    if (proto_viol != 0) begin
      errors++;
      $display("FAIL wr_en_protocol: got %0d violations required 0", proto_viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
